dsp48a1_mac_seq: RTL
====================

Name: dsp48a1_mac_seq

Overview:
Sequencer that drives one DSP48A1 slice as a signed 18x18 multiply-accumulate engine for a dot product of `len` operand pairs.
- Accepts a start command and a valid/ready operand stream.
- Issues operands and clock enables to the slice.
- Times OPMODE and CEP against the slice pipeline, tracking bubbles.
- Captures the 48-bit accumulated P and pulses `done`.

Fixed slice configuration: A0REG=0, B0REG=0, A1REG=1, B1REG=1, MREG=1, PREG=1, OPMODEREG=0, CARRYINREG=0, B_INPUT=DIRECT.

Parameters:
- LEN_W, 8, width of the `len` command field (maximum 2^LEN_W-1 pairs).
- PRE_LAT, 2, cycles from operand issue to that product being present at the X-mux (A1/B1 reg plus M reg).

Ports:
- clk  in  1  clock; all flops rise-edge.
- RST_N  in  1  reset, asynchronous, active-low.
- start  in  1  command strobe; sampled in IDLE only.
- len  in  LEN_W  number of pairs; sampled with start.
- a_in  in  18  signed operand A.
- b_in  in  18  signed operand B.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller accepts a pair this cycle.
- dsp_a  out  18  to slice A (= a_in, combinational).
- dsp_b  out  18  to slice B (= b_in, combinational).
- dsp_cea  out  1  slice CEA.
- dsp_ceb  out  1  slice CEB.
- dsp_cem  out  1  slice CEM.
- dsp_cep  out  1  slice CEP.
- dsp_opmode  out  8  slice OPMODE.
- dsp_p  in  48  slice P.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse; result valid.
- result  out  48  accumulated dot product; held until next accepted start.

Behaviour:
- Reset (RST_N=0, async): state IDLE, counters and valid pipe cleared. Outputs in_ready=0, all dsp_ce*=0, dsp_opmode=0, busy=0, done=0, result=0.
- Slice ports C, D, PCIN and CARRYIN are tied to 0 at the instance, outside this block.
- States:
  - IDLE: on start with len!=0, go to RUN and clear issue_cnt, ret_cnt, first flag. On start with len==0, go to DONE, result=0, no slice activity.
  - RUN: in_ready=1 while issue_cnt<len. Issue = in_valid&&in_ready, which sets dsp_cea=dsp_ceb=1 and issue_cnt++. When issue_cnt reaches len, go to DRAIN.
  - DRAIN: in_ready=0. Wait until ret_cnt==len, then for one more cycle so the last P load is visible, then go to DONE.
  - DONE: result<=dsp_p (len==0: 0), done=1 for this cycle only, then IDLE.
- Issue cycle: dsp_cea=dsp_ceb=issue; otherwise 0. dsp_a/dsp_b pass through regardless.
- dsp_cem=1 throughout RUN and DRAIN.
- Valid pipe: shift register of depth PRE_LAT carries the issue bit. Its output `ret` marks the cycle the element's product is at the X-mux.
- Retire cycle (ret=1):
  - dsp_cep=1, ret_cnt++.
  - dsp_opmode=8'b00000001 (X=M, Z=0) for the first retired element of a command; 8'b00001001 (X=M, Z=P) for every later one.
  - Pre-adder off; CARRYIN bit, pre-sub and post-sub are 0.
- Non-retire cycle (bubble or idle): dsp_cep=0 so P holds; dsp_opmode=8'b00001001 inside RUN/DRAIN, 0 otherwise.
- Latency: with the last issue at cycle t, its retire is at t+PRE_LAT, P is visible at t+PRE_LAT+1, and done is high at t+PRE_LAT+1 (DONE samples dsp_p that cycle). With no bubbles and len=N from the first issue at t0: done at t0+N-1+PRE_LAT+1.
- Arithmetic: 36-bit signed product sign-extended by the slice; 48-bit two's-complement wrap on accumulate, no saturation.
- A start outside IDLE is ignored. A start coincident with done is ignored; the earliest new start is accepted the cycle after done.
- in_valid while in_ready=0 is ignored; no pair is consumed.
- Reset mid-command: immediate IDLE and outputs to reset values. Any in-flight slice data is discarded, because the next command's first retire uses Z=0.

Test Plan:
1. len=4, pairs (20,10),(5,6),(-3,7),(100,100) back-to-back -> done exactly PRE_LAT+4 cycles after the first issue; result=48'h0000_0000_27E1 (10209); busy falls with done.
2. Same data as scenario 1 with in_valid low for 2 cycles after pair 2 -> dsp_cep low for exactly 2 retire-slot cycles; result still 48'h27E1; done delayed by 2 cycles.
3. len=1, pair (-131072,-131072) -> result=48'h0004_0000_0000; the single retire uses opmode 8'h01.
4. len=0 -> done the cycle after start, result=0; dsp_cea/ceb/cep never asserted.
5. len=3, with start re-pulsed during RUN and again in the DONE cycle -> both pulses ignored. A new start (len=1, (2,3)) the cycle after done gives result=6, with no carry-over from the prior result.
6. RST_N low mid-RUN (after 2 of 4 issues) -> outputs go to reset values asynchronously with no clk edge. After release, len=2 with (1,1),(1,1) gives result=2.

Source files
------------

// File: rtl/dsp48a1_mac_seq.sv
// Sequencer driving one DSP48A1 slice as a signed 18x18 multiply-accumulate engine.
// Operands stream in over valid/ready; P is captured into result when the dot product completes.
module dsp48a1_mac_seq #(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned PRE_LAT = 2
) (
    input  logic             clk,
    input  logic             RST_N,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [17:0]      a_in,
    input  logic [17:0]      b_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic             dsp_cea,
    output logic             dsp_ceb,
    output logic             dsp_cem,
    output logic             dsp_cep,
    output logic [7:0]       dsp_opmode,
    input  logic [47:0]      dsp_p,
    output logic             busy,
    output logic             done,
    output logic [47:0]      result
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [7:0] OpFirst = 8'b0000_0001;  // X=M, Z=0
    localparam logic [7:0] OpAcc   = 8'b0000_1001;  // X=M, Z=P

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   issue_cnt_q;
    logic [LEN_W-1:0]   ret_cnt_q;
    logic               first_q;
    logic               zero_len_q;
    logic [PRE_LAT-1:0] vpipe_q;
    logic [47:0]        result_q;

    logic issue;
    logic ret;
    logic active;
    logic last_issue;
    logic last_ret;

    always_comb begin
        active     = (state_q == StRun) || (state_q == StDrain);
        in_ready   = (state_q == StRun) && (issue_cnt_q < len_q);
        issue      = in_valid && in_ready;
        ret        = vpipe_q[PRE_LAT-1];
        last_issue = issue && (issue_cnt_q == len_q - LEN_W'(1));
        last_ret   = ret && (ret_cnt_q == len_q - LEN_W'(1));

        dsp_a   = a_in;
        dsp_b   = b_in;
        dsp_cea = issue;
        dsp_ceb = issue;
        dsp_cem = active;
        dsp_cep = ret;

        dsp_opmode = 8'h00;
        if (ret && first_q) begin
            dsp_opmode = OpFirst;
        end else if (active) begin
            dsp_opmode = OpAcc;
        end

        busy = (state_q != StIdle);
        done = (state_q == StDone);
        // P of the last retire is already visible in the DONE cycle, so expose it directly.
        result = result_q;
        if (done) begin
            result = zero_len_q ? 48'h0 : dsp_p;
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            len_q       <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            first_q     <= 1'b0;
            zero_len_q  <= 1'b0;
            vpipe_q     <= '0;
            result_q    <= 48'h0;
        end else begin
            vpipe_q <= PRE_LAT'({vpipe_q, issue});
            if (issue) begin
                issue_cnt_q <= issue_cnt_q + LEN_W'(1);
            end
            if (ret) begin
                ret_cnt_q <= ret_cnt_q + LEN_W'(1);
                first_q   <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        len_q       <= len;
                        issue_cnt_q <= '0;
                        ret_cnt_q   <= '0;
                        first_q     <= 1'b1;
                        zero_len_q  <= (len == '0);
                        state_q     <= (len == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (last_issue) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // The P load of the final retire lands on this edge, visible in DONE.
                    if (last_ret) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    result_q <= zero_len_q ? 48'h0 : dsp_p;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
